// File: rtl/exu_lsu.sv
// Load/store unit: single-outstanding request/grant/response bus master.
// Accepts one decoded memory op, drives it onto the data bus and returns
// aligned and extended load data, or flags misalignment, bus error or timeout.
//
// state | meaning
// IDLE  | ready for a new op
// REQ   | bus request raised, waiting for grant
// RESP  | granted, waiting for response (timeout counter running)
// DONE  | one-cycle completion, status and writeback presented
module exu_lsu #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TO_W           = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_lsu_valid,
   output logic        o_lsu_ready,
   input  logic        i_mem_rreq,
   input  logic        i_mem_wreq,
   input  logic [1:0]  i_lsu_size,
   input  logic        i_lsu_unsigned,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_lsu_wdata,
   input  logic [4:0]  i_lsu_rd,
   output logic        o_bus_req,
   input  logic        i_bus_gnt,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_wstrb,
   input  logic        i_bus_rvalid,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_err,
   output logic        o_lsu_done,
   output logic        o_wb_valid,
   output logic [4:0]  o_wb_rd,
   output logic [31:0] o_wb_data,
   output logic        o_lsu_misalign,
   output logic        o_lsu_err,
   output logic [31:0] o_lsu_badaddr
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [TO_W-1:0]   cnt_q;
   logic [31:0]       addr_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [4:0]        rd_q;
   logic [31:0]       bus_wdata_q;
   logic [3:0]        wstrb_q;
   logic              misalign_q;
   logic              err_q;
   logic [4:0]        wb_rd_q;
   logic [31:0]       wb_data_q;
   logic [31:0]       badaddr_q;

   logic              accept;
   logic              bad_op;
   logic              timeout;
   logic [31:0]       st_wdata;
   logic [3:0]        st_wstrb;
   logic [31:0]       ld_data;

   assign accept  = i_lsu_valid & o_lsu_ready;
   assign timeout = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Classify the incoming op: illegal encodings and misaligned addresses never reach the bus
   always_comb begin
      bad_op = 1'b0;
      if ((i_mem_rreq & i_mem_wreq) | (~i_mem_rreq & ~i_mem_wreq) | (i_lsu_size == 2'b11))
         bad_op = 1'b1;
      else if ((i_lsu_size == 2'b01) & i_lsu_addr[0])
         bad_op = 1'b1;
      else if ((i_lsu_size == 2'b10) & (i_lsu_addr[1:0] != 2'b00))
         bad_op = 1'b1;
   end

   // Store lane replication and byte enables; reads carry no strobes
   always_comb begin
      st_wdata = i_lsu_wdata;
      st_wstrb = 4'b0000;
      case (i_lsu_size)
         2'b00: begin
            st_wdata = {4{i_lsu_wdata[7:0]}};
            st_wstrb = 4'b0001 << i_lsu_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{i_lsu_wdata[15:0]}};
            st_wstrb = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = i_lsu_wdata;
            st_wstrb = 4'b1111;
         end
      endcase
      if (!i_mem_wreq)
         st_wstrb = 4'b0000;
   end

   // Load lane select and sign/zero extension
   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      b       = i_bus_rdata[8*addr_q[1:0] +: 8];
      h       = addr_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
      ld_data = i_bus_rdata;
      case (size_q)
         2'b00:   ld_data = uns_q ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   ld_data = uns_q ? {16'd0, h} : {{16{h[15]}}, h};
         default: ld_data = i_bus_rdata;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = bad_op ? S_DONE : S_REQ;
         S_REQ:   if (i_bus_gnt) state_d = S_RESP;
         S_RESP:  if (i_bus_rvalid | timeout) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; payload comes from registers so it holds outside DONE
   always_comb begin
      o_lsu_ready    = (state_q == S_IDLE) & ~rst;
      o_bus_req      = (state_q == S_REQ);
      o_bus_we       = (state_q == S_REQ) & we_q;
      o_bus_addr     = {addr_q[31:2], 2'b00};
      o_bus_wdata    = bus_wdata_q;
      o_bus_wstrb    = wstrb_q;
      o_lsu_done     = (state_q == S_DONE);
      o_wb_valid     = (state_q == S_DONE) & ~we_q & ~misalign_q & ~err_q;
      o_lsu_misalign = (state_q == S_DONE) & misalign_q;
      o_lsu_err      = (state_q == S_DONE) & err_q;
      o_wb_rd        = wb_rd_q;
      o_wb_data      = wb_data_q;
      o_lsu_badaddr  = badaddr_q;
   end

   // Op latch, timeout counter and completion payload
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         rd_q        <= '0;
         bus_wdata_q <= '0;
         wstrb_q     <= '0;
         misalign_q  <= 1'b0;
         err_q       <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         badaddr_q   <= '0;
      end else begin
         if (accept) begin
            addr_q      <= i_lsu_addr;
            we_q        <= i_mem_wreq;
            size_q      <= i_lsu_size;
            uns_q       <= i_lsu_unsigned;
            rd_q        <= i_lsu_rd;
            bus_wdata_q <= st_wdata;
            wstrb_q     <= st_wstrb;
            misalign_q  <= bad_op;
            err_q       <= 1'b0;
            if (bad_op) begin
               wb_rd_q   <= i_lsu_rd;
               badaddr_q <= i_lsu_addr;
            end
         end
         if ((state_q == S_REQ) & i_bus_gnt)
            cnt_q <= '0;
         else if ((state_q == S_RESP) & ~i_bus_rvalid & ~timeout)
            cnt_q <= cnt_q + TO_W'(1);
         if ((state_q == S_RESP) & (i_bus_rvalid | timeout)) begin
            wb_rd_q <= rd_q;
            if (i_bus_rvalid) begin
               err_q <= i_bus_err;
               if (i_bus_err) badaddr_q <= addr_q;
               else if (!we_q) wb_data_q <= ld_data;
            end else begin
               err_q     <= 1'b1;
               badaddr_q <= addr_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_exu_lsu.sv
// Directed bench for exu_lsu: loads, stores, misalignment, bus error,
// timeout and reset during a transaction.
module tb_exu_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_lsu_valid;
   logic        o_lsu_ready;
   logic        i_mem_rreq;
   logic        i_mem_wreq;
   logic [1:0]  i_lsu_size;
   logic        i_lsu_unsigned;
   logic [31:0] i_lsu_addr;
   logic [31:0] i_lsu_wdata;
   logic [4:0]  i_lsu_rd;
   logic        o_bus_req;
   logic        i_bus_gnt;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic [3:0]  o_bus_wstrb;
   logic        i_bus_rvalid;
   logic [31:0] i_bus_rdata;
   logic        i_bus_err;
   logic        o_lsu_done;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;
   logic        o_lsu_misalign;
   logic        o_lsu_err;
   logic [31:0] o_lsu_badaddr;

   int errors = 0;
   int checks = 0;
   int n;

   exu_lsu #(.TIMEOUT_CYCLES(256), .TO_W(8)) dut (
      .clk(clk), .rst(rst),
      .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
      .i_mem_rreq(i_mem_rreq), .i_mem_wreq(i_mem_wreq),
      .i_lsu_size(i_lsu_size), .i_lsu_unsigned(i_lsu_unsigned),
      .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata), .i_lsu_rd(i_lsu_rd),
      .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt), .o_bus_we(o_bus_we),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_wstrb(o_bus_wstrb),
      .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err),
      .o_lsu_done(o_lsu_done), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd),
      .o_wb_data(o_wb_data), .o_lsu_misalign(o_lsu_misalign), .o_lsu_err(o_lsu_err),
      .o_lsu_badaddr(o_lsu_badaddr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic rr, input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      i_mem_rreq     = rr;
      i_mem_wreq     = wr;
      i_lsu_size     = sz;
      i_lsu_unsigned = un;
      i_lsu_addr     = a;
      i_lsu_wdata    = wd;
      i_lsu_rd       = rd;
      i_lsu_valid    = 1'b1;
      tick();
      i_lsu_valid    = 1'b0;
   endtask

   task automatic grant();
      i_bus_gnt = 1'b1;
      tick();
      i_bus_gnt = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic e);
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = d;
      i_bus_err    = e;
      tick();
      i_bus_rvalid = 1'b0;
      i_bus_err    = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      i_lsu_valid = 0; i_mem_rreq = 0; i_mem_wreq = 0; i_lsu_size = 0; i_lsu_unsigned = 0;
      i_lsu_addr = 0; i_lsu_wdata = 0; i_lsu_rd = 0;
      i_bus_gnt = 0; i_bus_rvalid = 0; i_bus_rdata = 0; i_bus_err = 0;
      tick(); tick();
      chk("rst_ready", o_lsu_ready, 0);
      chk("rst_req", o_bus_req, 0);
      chk("rst_done", o_lsu_done, 0);
      chk("rst_wbdata", o_wb_data, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", o_lsu_ready, 1);

      // lw 0x100, minimum latency
      issue(1, 0, 2'b10, 0, 32'h100, 0, 5'd5);
      chk("lw_req", o_bus_req, 1);
      chk("lw_addr", o_bus_addr, 32'h100);
      chk("lw_we", o_bus_we, 0);
      chk("lw_wstrb", o_bus_wstrb, 0);
      chk("lw_ready_busy", o_lsu_ready, 0);
      grant();
      chk("lw_req_drop", o_bus_req, 0);
      chk("lw_not_done_yet", o_lsu_done, 0);
      respond(32'hDEADBEEF, 0);
      chk("lw_done", o_lsu_done, 1);
      chk("lw_wbv", o_wb_valid, 1);
      chk("lw_data", o_wb_data, 32'hDEADBEEF);
      chk("lw_rd", o_wb_rd, 5);
      chk("lw_err", o_lsu_err, 0);
      tick();
      chk("lw_done_pulse", o_lsu_done, 0);
      chk("lw_hold_data", o_wb_data, 32'hDEADBEEF);
      chk("lw_ready_back", o_lsu_ready, 1);

      // lb / lbu / lhu / lh
      issue(1, 0, 2'b00, 0, 32'h103, 0, 5'd6); grant(); respond(32'h80112233, 0);
      chk("lb_data", o_wb_data, 32'hFFFFFF80);
      chk("lb_wbv", o_wb_valid, 1);
      tick();
      issue(1, 0, 2'b00, 1, 32'h103, 0, 5'd7); grant(); respond(32'h80112233, 0);
      chk("lbu_data", o_wb_data, 32'h00000080);
      chk("lbu_rd", o_wb_rd, 7);
      tick();
      issue(1, 0, 2'b01, 1, 32'h102, 0, 5'd8); grant(); respond(32'h80112233, 0);
      chk("lhu_data", o_wb_data, 32'h00008011);
      tick();
      issue(1, 0, 2'b01, 0, 32'h100, 0, 5'd9); grant(); respond(32'h0000F00D, 0);
      chk("lh_data", o_wb_data, 32'hFFFFF00D);
      tick();

      // sh 0x202
      issue(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 5'd0);
      chk("sh_addr", o_bus_addr, 32'h200);
      chk("sh_wdata", o_bus_wdata, 32'hABCDABCD);
      chk("sh_wstrb", o_bus_wstrb, 4'b1100);
      chk("sh_we", o_bus_we, 1);
      grant(); respond(32'h0, 0);
      chk("sh_done", o_lsu_done, 1);
      chk("sh_no_wb", o_wb_valid, 0);
      chk("sh_wbdata_hold", o_wb_data, 32'hFFFFF00D);
      tick();

      // sb 0x201
      issue(0, 1, 2'b00, 0, 32'h201, 32'h0000005A, 5'd0);
      chk("sb_wdata", o_bus_wdata, 32'h5A5A5A5A);
      chk("sb_wstrb", o_bus_wstrb, 4'b0010);
      grant(); respond(32'h0, 0);
      chk("sb_done", o_lsu_done, 1);
      tick();

      // misaligned lw 0x101
      issue(1, 0, 2'b10, 0, 32'h101, 0, 5'd3);
      chk("mis_req", o_bus_req, 0);
      chk("mis_done", o_lsu_done, 1);
      chk("mis_flag", o_lsu_misalign, 1);
      chk("mis_badaddr", o_lsu_badaddr, 32'h101);
      chk("mis_no_wb", o_wb_valid, 0);
      tick();
      chk("mis_ready", o_lsu_ready, 1);
      chk("mis_flag_clear", o_lsu_misalign, 0);

      // illegal size and illegal rreq&wreq
      issue(1, 0, 2'b11, 0, 32'h104, 0, 5'd3);
      chk("ill_size", o_lsu_misalign, 1);
      tick();
      issue(1, 1, 2'b10, 0, 32'h108, 0, 5'd3);
      chk("ill_both", o_lsu_misalign, 1);
      chk("ill_both_badaddr", o_lsu_badaddr, 32'h108);
      tick();

      // delayed grant then bus error
      issue(1, 0, 2'b10, 0, 32'h300, 0, 5'd4);
      for (int i = 0; i < 5; i++) begin
         chk("wait_req", o_bus_req, 1);
         chk("wait_addr", o_bus_addr, 32'h300);
         tick();
      end
      grant(); respond(32'h12345678, 1);
      chk("berr_done", o_lsu_done, 1);
      chk("berr_err", o_lsu_err, 1);
      chk("berr_no_wb", o_wb_valid, 0);
      chk("berr_badaddr", o_lsu_badaddr, 32'h300);
      tick();

      // timeout
      issue(1, 0, 2'b10, 0, 32'h400, 0, 5'd2);
      grant();
      n = 0;
      while (!o_lsu_done && n < 400) begin
         tick();
         n++;
      end
      chk("to_cycles", n, 256);
      chk("to_err", o_lsu_err, 1);
      chk("to_no_wb", o_wb_valid, 0);
      chk("to_badaddr", o_lsu_badaddr, 32'h400);
      tick();
      respond(32'hCAFEF00D, 0);
      chk("late_rvalid_ignored", o_lsu_done, 0);
      chk("late_ready", o_lsu_ready, 1);

      // reset while in REQ
      issue(1, 0, 2'b10, 0, 32'h500, 0, 5'd1);
      chk("rst_mid_req", o_bus_req, 1);
      rst = 1'b1;
      tick();
      chk("rst_mid_req_drop", o_bus_req, 0);
      chk("rst_mid_ready_low", o_lsu_ready, 0);
      rst = 1'b0;
      #1;
      chk("rst_mid_ready_back", o_lsu_ready, 1);
      respond(32'h11111111, 0);
      chk("stale_no_done", o_lsu_done, 0);
      chk("stale_no_wb", o_wb_valid, 0);
      chk("stale_no_req", o_bus_req, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
